// File: rtl/id_ex_stage_pkg.sv
// Shared core definitions: ALU op codes and the ID/EX pipeline bundle.
// Decode, ID/EX and EX/MEM all import this package.
package id_ex_stage_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rd;
    logic [3:0]        alu_ctrl;
    logic              use_imm;
    logic              reg_we;
    logic              mem_read;
    logic              mem_write;
  } id_ex_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand bypass: MEM result beats WB result beats register file data.
// x0 is hardwired to zero and never takes a bypass.
module fwd_mux #(
  parameter int W = 32
) (
  input  logic [4:0]   i_rs,
  input  logic [W-1:0] i_rs_data,
  input  logic         i_mem_we,
  input  logic [4:0]   i_mem_rd,
  input  logic [W-1:0] i_mem_data,
  input  logic         i_wb_we,
  input  logic [4:0]   i_wb_rd,
  input  logic [W-1:0] i_wb_data,
  output logic [W-1:0] o_fwd
);

  logic w_nz;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_nz      = (i_rs != 5'd0);
  assign w_mem_hit = i_mem_we & (i_mem_rd == i_rs) & w_nz;
  assign w_wb_hit  = i_wb_we & (i_wb_rd == i_rs) & w_nz;

  always_comb begin
    o_fwd = i_rs_data;
    if (w_mem_hit)
      o_fwd = i_mem_data;
    else if (w_wb_hit)
      o_fwd = i_wb_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding
// and single-bubble load-use interlock.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN  = DATA_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [3:0]       id_alu_ctrl,
  input  logic             id_use_imm,
  input  logic             id_reg_we,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             ex_ready,
  input  logic             flush,
  input  logic             mem_fwd_we,
  input  logic [4:0]       mem_fwd_rd,
  input  logic [XLEN-1:0]  mem_fwd_data,
  input  logic             wb_fwd_we,
  input  logic [4:0]       wb_fwd_rd,
  input  logic [XLEN-1:0]  wb_fwd_data,
  output logic             ex_valid,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [3:0]       alu_ctrl,
  output logic [XLEN-1:0]  ex_store_data,
  output logic [XLEN-1:0]  ex_pc,
  output logic [4:0]       ex_rd,
  output logic             ex_reg_we,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic [CNT_W-1:0] bubble_count
);

  id_ex_t           r_q;
  id_ex_t           w_id;
  logic [CNT_W-1:0] r_cnt;
  logic             w_rs1_hit;
  logic             w_rs2_hit;
  logic             w_lu_hazard;
  logic [XLEN-1:0]  w_fwd1;
  logic [XLEN-1:0]  w_fwd2;

  always_comb begin
    w_id           = '0;
    w_id.valid     = id_valid;
    w_id.pc        = id_pc;
    w_id.rs1       = id_rs1;
    w_id.rs2       = id_rs2;
    w_id.rs1_data  = id_rs1_data;
    w_id.rs2_data  = id_rs2_data;
    w_id.imm       = id_imm;
    w_id.rd        = id_rd;
    w_id.alu_ctrl  = id_alu_ctrl;
    w_id.use_imm   = id_use_imm;
    w_id.reg_we    = id_reg_we;
    w_id.mem_read  = id_mem_read;
    w_id.mem_write = id_mem_write;
  end

  assign w_rs1_hit   = id_uses_rs1 & (id_rs1 == r_q.rd);
  assign w_rs2_hit   = id_uses_rs2 & (id_rs2 == r_q.rd);
  assign w_lu_hazard = r_q.valid & r_q.mem_read & (r_q.rd != 5'd0)
                     & (w_rs1_hit | w_rs2_hit);

  assign id_ready = ex_ready & ~w_lu_hazard & ~flush;

  // Flush outranks stall; a hazard bubbles without touching the fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_q.valid <= 1'b0;
    end else if (!ex_ready) begin
      r_q <= r_q;
    end else if (w_lu_hazard) begin
      r_q.valid <= 1'b0;
      if (r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
    end else begin
      r_q <= w_id;
    end
  end

  fwd_mux #(.W(XLEN)) u_fwd_rs1 (
    .i_rs       (r_q.rs1),
    .i_rs_data  (r_q.rs1_data),
    .i_mem_we   (mem_fwd_we),
    .i_mem_rd   (mem_fwd_rd),
    .i_mem_data (mem_fwd_data),
    .i_wb_we    (wb_fwd_we),
    .i_wb_rd    (wb_fwd_rd),
    .i_wb_data  (wb_fwd_data),
    .o_fwd      (w_fwd1)
  );

  fwd_mux #(.W(XLEN)) u_fwd_rs2 (
    .i_rs       (r_q.rs2),
    .i_rs_data  (r_q.rs2_data),
    .i_mem_we   (mem_fwd_we),
    .i_mem_rd   (mem_fwd_rd),
    .i_mem_data (mem_fwd_data),
    .i_wb_we    (wb_fwd_we),
    .i_wb_rd    (wb_fwd_rd),
    .i_wb_data  (wb_fwd_data),
    .o_fwd      (w_fwd2)
  );

  assign ex_valid      = r_q.valid;
  assign alu_a         = w_fwd1;
  assign alu_b         = r_q.use_imm ? r_q.imm : w_fwd2;
  assign alu_ctrl      = r_q.alu_ctrl;
  assign ex_store_data = w_fwd2;
  assign ex_pc         = r_q.pc;
  assign ex_rd         = r_q.rd;
  assign ex_reg_we     = r_q.valid & r_q.reg_we;
  assign ex_mem_read   = r_q.valid & r_q.mem_read;
  assign ex_mem_write  = r_q.valid & r_q.mem_write;
  assign bubble_count  = r_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage with a queued scoreboard
// checked by an independent negedge monitor.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int XL = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_ready;
  logic [XL-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          id_uses_rs1, id_uses_rs2;
  logic [3:0]    id_alu_ctrl;
  logic          id_use_imm, id_reg_we, id_mem_read, id_mem_write;
  logic          ex_ready, flush;
  logic          mem_fwd_we, wb_fwd_we;
  logic [4:0]    mem_fwd_rd, wb_fwd_rd;
  logic [XL-1:0] mem_fwd_data, wb_fwd_data;
  logic          ex_valid;
  logic [XL-1:0] alu_a, alu_b, ex_store_data, ex_pc;
  logic [3:0]    alu_ctrl;
  logic [4:0]    ex_rd;
  logic          ex_reg_we, ex_mem_read, ex_mem_write;
  logic [CW-1:0] bubble_count;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_alu_ctrl(id_alu_ctrl), .id_use_imm(id_use_imm),
    .id_reg_we(id_reg_we), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write),
    .ex_ready(ex_ready), .flush(flush),
    .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd),
    .mem_fwd_data(mem_fwd_data),
    .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd),
    .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .ex_store_data(ex_store_data),
    .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .bubble_count(bubble_count)
  );

  typedef struct {
    string         name;
    logic          chk;
    logic          v, idr, we, mr, mw;
    logic [CW-1:0] bc;
    logic [XL-1:0] a, b, st;
    logic [3:0]    ctrl;
    logic [4:0]    rd;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Monitor: every pending expectation is compared at the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic ok;
      e  = q.pop_front();
      ok = (ex_valid === e.v) && (id_ready === e.idr)
        && (ex_reg_we === e.we) && (ex_mem_read === e.mr)
        && (ex_mem_write === e.mw) && (bubble_count === e.bc);
      if (e.chk)
        ok = ok && (alu_a === e.a) && (alu_b === e.b)
          && (ex_store_data === e.st) && (alu_ctrl === e.ctrl)
          && (ex_rd === e.rd);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL %s: got v=%b idr=%b we=%b mr=%b mw=%b bc=%0d a=%h b=%h st=%h ctrl=%h rd=%0d; want v=%b idr=%b we=%b mr=%b mw=%b bc=%0d a=%h b=%h st=%h ctrl=%h rd=%0d (data chk=%b)",
          e.name, ex_valid, id_ready, ex_reg_we, ex_mem_read,
          ex_mem_write, bubble_count, alu_a, alu_b, ex_store_data,
          alu_ctrl, ex_rd, e.v, e.idr, e.we, e.mr, e.mw, e.bc,
          e.a, e.b, e.st, e.ctrl, e.rd, e.chk);
      end
    end
  end

  task automatic exp_ctl(input string n, input logic v,
                         input logic we, input logic mr,
                         input logic idr, input int bc);
    exp_t e;
    e = '{name: n, chk: 1'b0, v: v, idr: idr, we: we, mr: mr,
          mw: 1'b0, bc: CW'(bc), a: '0, b: '0, st: '0,
          ctrl: '0, rd: '0};
    q.push_back(e);
  endtask

  task automatic exp_full(input string n, input logic v,
                          input logic [XL-1:0] a, input logic [XL-1:0] b,
                          input logic [XL-1:0] st, input logic [3:0] ctrl,
                          input logic [4:0] rd, input logic we,
                          input logic mr, input logic idr, input int bc);
    exp_t e;
    e = '{name: n, chk: 1'b1, v: v, idr: idr, we: we, mr: mr,
          mw: 1'b0, bc: CW'(bc), a: a, b: b, st: st,
          ctrl: ctrl, rd: rd};
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [XL-1:0] d1,
                       input logic [XL-1:0] d2, input logic [XL-1:0] imm,
                       input logic [3:0] ctrl, input logic ui,
                       input logic mr);
    id_valid     = 1'b1;
    id_pc        = 32'h100;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_rs1_data  = d1;
    id_rs2_data  = d2;
    id_imm       = imm;
    id_alu_ctrl  = ctrl;
    id_use_imm   = ui;
    id_uses_rs1  = 1'b1;
    id_uses_rs2  = ~ui;
    id_reg_we    = 1'b1;
    id_mem_read  = mr;
    id_mem_write = 1'b0;
  endtask

  task automatic issue_lw();
    issue(5'd1, 5'd0, 5'd5, 32'h1000, 32'h0, 32'd4, ALU_ADD, 1'b1, 1'b1);
  endtask

  task automatic issue_sub();
    issue(5'd5, 5'd1, 5'd6, 32'hDEAD, 32'd3, 32'h0, ALU_SUB, 1'b0, 1'b0);
  endtask

  int cnt;

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0;
    id_imm = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_alu_ctrl = 0;
    id_use_imm = 0; id_reg_we = 0; id_mem_read = 0; id_mem_write = 0;
    ex_ready = 1; flush = 0;
    mem_fwd_we = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_we = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
    #1;
    exp_full("reset", 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 1, 0);
    tick(); tick();
    rst_n = 1'b1;

    issue(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, ALU_ADD, 1'b0, 1'b0);
    exp_ctl("add_accept", 0, 0, 0, 1, 0);
    tick();
    id_valid = 0;
    exp_full("add_issue", 1, 5, 7, 7, ALU_ADD, 3, 1, 0, 1, 0);
    tick();

    issue(5'd4, 5'd0, 5'd7, 32'h11, 32'h0, 32'h20, ALU_OR, 1'b1, 1'b0);
    exp_ctl("or_accept", 0, 0, 0, 1, 0);
    tick();
    id_valid = 0; ex_ready = 0;
    mem_fwd_we = 1; mem_fwd_rd = 4; mem_fwd_data = 32'hAA;
    wb_fwd_we = 1;  wb_fwd_rd = 4;  wb_fwd_data = 32'hBB;
    exp_full("mem_over_wb", 1, 32'hAA, 32'h20, 0, ALU_OR, 7, 1, 0, 0, 0);
    tick();
    mem_fwd_we = 0;
    exp_full("wb_fwd", 1, 32'hBB, 32'h20, 0, ALU_OR, 7, 1, 0, 0, 0);
    tick();
    wb_fwd_we = 0;
    exp_full("stall_hold", 1, 32'h11, 32'h20, 0, ALU_OR, 7, 1, 0, 0, 0);
    tick();

    ex_ready = 1;
    mem_fwd_we = 1; mem_fwd_rd = 0; mem_fwd_data = 32'h55;
    issue(5'd0, 5'd2, 5'd8, 32'h0, 32'd9, 32'h0, ALU_ADD, 1'b0, 1'b0);
    exp_full("stall_resume", 1, 32'h11, 32'h20, 0, ALU_OR, 7, 1, 0, 1, 0);
    tick();
    id_valid = 0;
    wb_fwd_we = 1; wb_fwd_rd = 0; wb_fwd_data = 32'h66;
    exp_full("x0_nofwd", 1, 0, 9, 9, ALU_ADD, 8, 1, 0, 1, 0);
    tick();

    mem_fwd_we = 0; wb_fwd_we = 0;
    issue_lw();
    exp_ctl("lw_accept", 0, 0, 0, 1, 0);
    tick();
    issue_sub();
    exp_full("lu_hazard", 1, 32'h1000, 4, 0, ALU_ADD, 5, 1, 1, 0, 0);
    tick();
    exp_ctl("lu_bubble", 0, 0, 0, 1, 1);
    tick();
    id_valid = 0;
    wb_fwd_we = 1; wb_fwd_rd = 5; wb_fwd_data = 32'h77;
    exp_full("sub_wb_fwd", 1, 32'h77, 3, 3, ALU_SUB, 6, 1, 0, 1, 1);
    tick();

    wb_fwd_we = 0;
    issue_lw();
    exp_ctl("lw2_accept", 0, 0, 0, 1, 1);
    tick();
    issue_sub();
    flush = 1;
    exp_full("flush_hazard", 1, 32'h1000, 4, 0, ALU_ADD, 5, 1, 1, 0, 1);
    tick();
    flush = 0; id_valid = 0;
    exp_ctl("flush_no_count", 0, 0, 0, 1, 1);
    tick();

    cnt = 1;
    for (int k = 0; k < 16; k++) begin
      issue_lw();
      exp_ctl("sat_lw", 0, 0, 0, 1, cnt);
      tick();
      issue_sub();
      exp_ctl("sat_hazard", 1, 1, 1, 0, cnt);
      tick();
      if (cnt < (1 << CW) - 1) cnt++;
      exp_ctl("sat_bubble", 0, 0, 0, 1, cnt);
      tick();
      id_valid = 0;
      exp_ctl("sat_sub", 1, 1, 0, 1, cnt);
      tick();
    end
    exp_ctl("sat_final", 0, 0, 0, 1, 15);
    tick();

    issue(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, ALU_SUB, 1'b0, 1'b0);
    tick();
    id_valid = 0;
    exp_full("pre_reset", 1, 5, 7, 7, ALU_SUB, 3, 1, 0, 1, 15);
    tick();
    rst_n = 0;
    exp_full("mid_reset", 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 1, 0);
    tick();
    rst_n = 1;
    tick(); tick();

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
